// File: rtl/mem_arb_pkg.sv
// Shared encodings and constants for the fetch/data memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } arb_state_e;

   typedef enum logic {
      OWN_IF,
      OWN_D
   } arb_owner_e;

   localparam logic [31:0] MEM_ARB_ERR_DATA = 32'hDEADBEEF;
   localparam logic [3:0]  MEM_FETCH_BE     = 4'hF;

endpackage

// File: rtl/mem_arb_watchdog.sv
// WAIT-state timeout counter; only built when MEM_ARB_TIMEOUT_EN is defined.
`ifdef MEM_ARB_TIMEOUT_EN
module mem_arb_watchdog #(
   parameter int TIMEOUT_CYC = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic clear,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT_CYC + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                   cnt <= '0;
      else if (clear)            cnt <= '0;
      else if (start && !expired) cnt <= cnt + CW'(1);
   end

   // Fires during the TIMEOUT_CYC-th consecutive counting cycle.
   assign expired = start && (cnt == CW'(TIMEOUT_CYC - 1));

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and data access.
// Optional WAIT timeout with sticky err is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int STARVE_MAX  = 4,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [3:0]  d_be,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        stall_if,
   output logic        stall_mem,
   output logic        err
);

   if (STARVE_MAX < 1 || STARVE_MAX > 7 || TIMEOUT_CYC < 1) begin : g_param_check
      $error("mem_port_arbiter: STARVE_MAX must be 1..7 and TIMEOUT_CYC >= 1");
   end

   localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

   arb_state_e  state, state_nxt;
   arb_owner_e  owner, owner_nxt;
   logic [2:0]  starve_cnt;
   logic        start_txn, grant, rsp_take, rsp_err, timeout;
   logic [31:0] rsp_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         owner <= OWN_IF;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         state <= state_nxt;
         owner <= owner_nxt;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_nxt = state;
      owner_nxt = owner;
      start_txn = 1'b0;
      grant     = 1'b0;
      rsp_take  = 1'b0;
      rsp_err   = 1'b0;
      case (state)
         IDLE: begin
            if (if_req || d_req) begin
               start_txn = 1'b1;
               state_nxt = ISSUE;
               // Data belongs to the older instruction unless fetch has waited too long.
               if (d_req && (starve_cnt < STARVE_LIM)) owner_nxt = OWN_D;
               else if (if_req)                         owner_nxt = OWN_IF;
               else                                     owner_nxt = OWN_D;
            end
         end
         ISSUE: begin
            if (mem_ready) begin
               grant     = 1'b1;
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (mem_rvalid) begin
               rsp_take  = 1'b1;
               state_nxt = RESP;
            end else if (timeout) begin
               rsp_take  = 1'b1;
               rsp_err   = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign rsp_data = rsp_err ? MEM_ARB_ERR_DATA : mem_rdata;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_be    <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_rvalid <= 1'b0;
         d_rvalid  <= 1'b0;
         if_rdata  <= '0;
         d_rdata   <= '0;
      end else begin
         if_rvalid <= rsp_take && (owner == OWN_IF);
         d_rvalid  <= rsp_take && (owner == OWN_D);
         if (start_txn) begin
            mem_req <= 1'b1;
            if (owner_nxt == OWN_D) begin
               mem_we    <= d_we;
               mem_be    <= d_be;
               mem_addr  <= d_addr;
               mem_wdata <= d_wdata;
            end else begin
               mem_we    <= 1'b0;
               mem_be    <= MEM_FETCH_BE;
               mem_addr  <= if_addr;
               mem_wdata <= '0;
            end
         end else if (grant) begin
            mem_req <= 1'b0;
         end
         if (rsp_take) begin
            if (owner == OWN_IF)        if_rdata <= rsp_data;
            else if (mem_we && !rsp_err) d_rdata  <= '0;
            else                         d_rdata  <= rsp_data;
         end
      end
   end

   // Saturating count of data grants made while fetch is waiting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                         starve_cnt <= '0;
      else if (!if_req)                                starve_cnt <= '0;
      else if (grant && (owner == OWN_IF))             starve_cnt <= '0;
      else if (grant && (starve_cnt != 3'd7))          starve_cnt <= starve_cnt + 3'd1;
   end

   assign if_gnt    = (state == ISSUE) && mem_ready && (owner == OWN_IF);
   assign d_gnt     = (state == ISSUE) && mem_ready && (owner == OWN_D);
   assign stall_if  = if_req & ~if_rvalid;
   assign stall_mem = d_req & ~d_rvalid;

`ifdef MEM_ARB_TIMEOUT_EN
   logic err_q;

   mem_arb_watchdog #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .start   (state == WAIT),
      .clear   (state != WAIT),
      .expired (timeout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          err_q <= 1'b0;
      else if (rsp_err) err_q <= 1'b1;
   end

   assign err = err_q;
`else
   assign timeout = 1'b0;
   assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests, a small memory model and an rvalid monitor.
module tb_mem_port_arbiter;

   logic        clk, rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt, if_rvalid;
   logic [31:0] if_rdata;
   logic        d_req, d_we;
   logic [3:0]  d_be;
   logic [31:0] d_addr, d_wdata;
   logic        d_gnt, d_rvalid;
   logic [31:0] d_rdata;
   logic        mem_req, mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_ready, mem_rvalid;
   logic [31:0] mem_rdata;
   logic        stall_if, stall_mem, err;

   typedef struct {
      bit          is_d;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];
   int   tests  = 0;
   int   errors = 0;
   int   ready_wait = 0;
   int   rsp_delay  = 0;
   bit   drop_rsp   = 0;

   mem_port_arbiter #(
      .STARVE_MAX  (4),
      .TIMEOUT_CYC (64)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .if_req     (if_req),
      .if_addr    (if_addr),
      .if_gnt     (if_gnt),
      .if_rvalid  (if_rvalid),
      .if_rdata   (if_rdata),
      .d_req      (d_req),
      .d_we       (d_we),
      .d_be       (d_be),
      .d_addr     (d_addr),
      .d_wdata    (d_wdata),
      .d_gnt      (d_gnt),
      .d_rvalid   (d_rvalid),
      .d_rdata    (d_rdata),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_be     (mem_be),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_ready  (mem_ready),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .stall_if   (stall_if),
      .stall_mem  (stall_mem),
      .err        (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

   function automatic logic [31:0] rsp_for(input logic [31:0] a);
      return (a == 32'h0000_0100) ? 32'h0050_0093 : (a ^ 32'h1357_9BDF);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic expect_rsp(input bit is_d, input logic [31:0] data);
      exp_t e;
      e.is_d = is_d;
      e.data = data;
      sb.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_gnt(output bit got_d, output bit ok);
      ok    = 1'b0;
      got_d = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (if_gnt || d_gnt) begin
            got_d = d_gnt;
            ok    = 1'b1;
            break;
         end
      end
      if (!ok) begin
         tests++;
         errors++;
         $display("FAIL gnt_timeout: got no grant in 40 cycles, expected a grant");
      end
   endtask

   task automatic wait_rvalid(input bit is_d, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 120; i++) begin
         @(negedge clk);
         if (is_d ? d_rvalid : if_rvalid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         tests++;
         errors++;
         $display("FAIL rvalid_timeout: got no rvalid (is_d=%0d) in 120 cycles, expected one", is_d);
      end
   endtask

   // Memory model: ready after ready_wait cycles of mem_req, response rsp_delay cycles after acceptance.
   initial begin : mem_model
      bit          hs, pend;
      int          dcnt, rcnt;
      logic [31:0] hs_addr;
      hs = 0; pend = 0; dcnt = 0; rcnt = 0; hs_addr = '0;
      mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         mem_rvalid = 1'b0;
         if (hs && !drop_rsp) begin
            pend = 1;
            dcnt = rsp_delay;
         end
         if (pend) begin
            if (dcnt == 0) begin
               mem_rvalid = 1'b1;
               mem_rdata  = rsp_for(hs_addr);
               pend       = 0;
            end else begin
               dcnt--;
            end
         end
         if (mem_req) begin
            mem_ready = (rcnt >= ready_wait);
            rcnt++;
         end else begin
            mem_ready = 1'b0;
            rcnt      = 0;
         end
         hs = mem_req && mem_ready;
         if (hs) hs_addr = mem_addr;
      end
   end

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (if_rvalid || d_rvalid) begin
            if (sb.size() == 0) begin
               tests++;
               errors++;
               $display("FAIL unexpected_rvalid: got if_rvalid=%0b d_rvalid=%0b, expected no response",
                        if_rvalid, d_rvalid);
            end else begin
               e = sb.pop_front();
               check("rsp_if_rvalid", 32'(if_rvalid), 32'(!e.is_d));
               check("rsp_d_rvalid", 32'(d_rvalid), 32'(e.is_d));
               check("rsp_rdata", e.is_d ? d_rdata : if_rdata, e.data);
            end
         end
      end
   end

   initial begin : stimulus
      bit got_d, ok, exp_d;
      int dn, seen;
      rst = 1'b1;
      if_req = 0; if_addr = '0;
      d_req = 0; d_we = 0; d_be = '0; d_addr = '0; d_wdata = '0;
      tick();
      tick();

      // Reset values
      @(negedge clk);
      check("rst_mem_req", 32'(mem_req), 0);
      check("rst_mem_we", 32'(mem_we), 0);
      check("rst_mem_be", 32'(mem_be), 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_rvalids", 32'({if_rvalid, d_rvalid}), 0);
      check("rst_gnts", 32'({if_gnt, d_gnt}), 0);
      check("rst_if_rdata", if_rdata, 0);
      check("rst_d_rdata", d_rdata, 0);
      check("rst_err", 32'(err), 0);

      // Single fetch at minimum latency
      tick();
      rst = 1'b0;
      if_req = 1; if_addr = 32'h100;
      expect_rsp(0, 32'h0050_0093);
      @(negedge clk);
      check("fetch_c0_stall_if", 32'(stall_if), 1);
      check("fetch_c0_mem_req", 32'(mem_req), 0);
      tick(); @(negedge clk);
      check("fetch_c1_if_gnt", 32'(if_gnt), 1);
      check("fetch_c1_d_gnt", 32'(d_gnt), 0);
      check("fetch_c1_mem_req", 32'(mem_req), 1);
      check("fetch_c1_mem_addr", mem_addr, 32'h100);
      check("fetch_c1_mem_be", 32'(mem_be), 32'hF);
      check("fetch_c1_mem_we", 32'(mem_we), 0);
      tick(); @(negedge clk);
      check("fetch_c2_if_gnt", 32'(if_gnt), 0);
      check("fetch_c2_mem_req", 32'(mem_req), 0);
      tick(); @(negedge clk);
      check("fetch_c3_if_rvalid", 32'(if_rvalid), 1);
      check("fetch_c3_stall_if", 32'(stall_if), 0);
      tick();
      if_req = 0;
      @(negedge clk);
      check("fetch_c4_if_rvalid", 32'(if_rvalid), 0);

      // Simultaneous requests: data first, fetch issued from the next IDLE
      tick();
      if_req = 1; if_addr = 32'h200;
      d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h2000;
      expect_rsp(1, rsp_for(32'h2000));
      expect_rsp(0, rsp_for(32'h200));
      tick(); @(negedge clk);
      check("sim_c1_d_gnt", 32'(d_gnt), 1);
      check("sim_c1_if_gnt", 32'(if_gnt), 0);
      check("sim_c1_mem_addr", mem_addr, 32'h2000);
      tick(); tick(); @(negedge clk);
      check("sim_c3_d_rvalid", 32'(d_rvalid), 1);
      tick();
      d_req = 0;
      @(negedge clk);
      check("sim_c4_mem_req", 32'(mem_req), 0);
      tick(); @(negedge clk);
      check("sim_c5_if_gnt", 32'(if_gnt), 1);
      check("sim_c5_mem_addr", mem_addr, 32'h200);
      check("sim_c5_mem_be", 32'(mem_be), 32'hF);
      wait_rvalid(0, ok);
      tick();
      if_req = 0;

      // Starvation: fetch held, data re-requested after every response
      rsp_delay = 1;
      tick();
      if_req = 1; if_addr = 32'h300;
      d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h3000;
      dn = 0;
      for (int g = 0; g < 6; g++) begin
         if (g == 4) begin
            expect_rsp(0, rsp_for(32'h300));
         end else begin
            expect_rsp(1, rsp_for(32'h3000 + 32'(4 * dn)));
            dn++;
         end
      end
      dn = 0;
      for (int g = 0; g < 6; g++) begin
         wait_gnt(got_d, ok);
         if (!ok) break;
         exp_d = (g != 4);
         check($sformatf("starve_grant%0d_is_d", g), 32'(got_d), 32'(exp_d));
         wait_rvalid(got_d, ok);
         if (!ok) break;
         tick();
         if (got_d) begin
            dn++;
            d_addr = 32'h3000 + 32'(4 * dn);
         end
      end
      if_req = 0;
      d_req  = 0;

      // Store held off by mem_ready for three cycles
      rsp_delay  = 0;
      ready_wait = 3;
      tick();
      d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h4000; d_wdata = 32'hCAFE_BABE;
      expect_rsp(1, 32'h0);
      @(negedge clk);
      check("store_c0_stall_mem", 32'(stall_mem), 1);
      for (int k = 1; k <= 4; k++) begin
         tick(); @(negedge clk);
         check($sformatf("store_c%0d_mem_req", k), 32'(mem_req), 1);
         check($sformatf("store_c%0d_mem_we", k), 32'(mem_we), 1);
         check($sformatf("store_c%0d_mem_be", k), 32'(mem_be), 32'h3);
         check($sformatf("store_c%0d_mem_addr", k), mem_addr, 32'h4000);
         check($sformatf("store_c%0d_mem_wdata", k), mem_wdata, 32'hCAFE_BABE);
         check($sformatf("store_c%0d_d_gnt", k), 32'(d_gnt), 32'(k == 4));
         check($sformatf("store_c%0d_stall_mem", k), 32'(stall_mem), 1);
      end
      tick(); @(negedge clk);
      check("store_c5_mem_req", 32'(mem_req), 0);
      check("store_c5_stall_mem", 32'(stall_mem), 1);
      tick(); @(negedge clk);
      check("store_c6_d_rvalid", 32'(d_rvalid), 1);
      check("store_c6_stall_mem", 32'(stall_mem), 0);
      tick();
      d_req = 0; d_we = 0;
      ready_wait = 0;

      // Reset during WAIT; the late response must be dropped
      rsp_delay = 3;
      tick();
      d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h5000;
      wait_gnt(got_d, ok);
      tick();
      tick();
      rst = 1'b1;
      d_req = 0;
      @(negedge clk);
      check("wrst_mem_req", 32'(mem_req), 0);
      check("wrst_mem_addr", mem_addr, 0);
      check("wrst_mem_be", 32'(mem_be), 0);
      check("wrst_if_rdata", if_rdata, 0);
      check("wrst_rvalids", 32'({if_rvalid, d_rvalid}), 0);
      tick();
      rst = 1'b0;
      seen = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (if_rvalid || d_rvalid || mem_req) seen++;
         tick();
      end
      check("wrst_late_rsp_activity", 32'(seen), 0);

      // Recovery after reset
      rsp_delay = 0;
      d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h6000;
      expect_rsp(1, rsp_for(32'h6000));
      wait_rvalid(1, ok);
      check("recover_err", 32'(err), 0);
      tick();
      d_req = 0;

`ifdef MEM_ARB_TIMEOUT_EN
      // Response never arrives: timeout returns the error word and sets err
      drop_rsp = 1;
      tick();
      d_req = 1; d_addr = 32'h7000;
      expect_rsp(1, 32'hDEAD_BEEF);
      wait_rvalid(1, ok);
      check("timeout_err", 32'(err), 1);
      tick();
      d_req = 0;
      drop_rsp = 0;
      tick();
      d_req = 1; d_addr = 32'h7004;
      expect_rsp(1, rsp_for(32'h7004));
      wait_rvalid(1, ok);
      check("timeout_err_sticky", 32'(err), 1);
      tick();
      d_req = 0;
`endif

      tick(); tick();
      check("scoreboard_drained", 32'(sb.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
